// File: rtl/ready_gen_pkg.sv
// Shared types and helpers for the ready pattern generator.
package ready_gen_pkg;

  typedef enum logic [2:0] {
    RDY_RANDOM = 3'd0,
    RDY_TOGGLE = 3'd1,
    RDY_BURST  = 3'd2,
    RDY_HIGH   = 3'd3,
    RDY_LOW    = 3'd4
  } rdy_mode_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Per-channel seed: base seed scrambled by channel index, never zero
  // (an all-zero Galois LFSR would lock up).
  function automatic logic [15:0] chan_seed(input logic [15:0] seed, input int c);
    logic [31:0] mult;
    logic [15:0] s;
    mult = 32'h1111 * 32'(c + 1);
    s    = seed ^ mult[15:0];
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/ready_chan_gen.sv
// One ready channel: LFSR, burst phase counter, stall cap and optional
// stall statistics. Stats counter is built only when READY_GEN_STATS_EN
// is defined; otherwise stall_total_o is tied to zero.
module ready_chan_gen
  import ready_gen_pkg::*;
#(
  parameter int          CNT_W     = 8,
  parameter logic [15:0] SEED      = 16'h0001,
  parameter int unsigned MAX_STALL = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic [7:0]       thresh_i,
  input  logic [CNT_W-1:0] on_len_i,
  input  logic [CNT_W-1:0] off_len_i,
  output logic             ready_o,
  output logic [31:0]      stall_total_o
);

  logic             ready_q, ready_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_on_q, phase_on_d;
  logic [31:0]      stall_q, stall_d;
  logic             mode_rdy;
  logic [CNT_W:0]   cnt_inc;

  // Next-state: mode decision, burst sequencing, stall cap override.
  always_comb begin
    lfsr_d     = lfsr_q;
    ready_d    = 1'b1;
    cnt_d      = '0;
    phase_on_d = 1'b1;
    stall_d    = '0;
    mode_rdy   = 1'b1;
    cnt_inc    = {1'b0, cnt_q} + 1'b1;
    if (en_i) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      case (rdy_mode_e'(mode_i))
        RDY_RANDOM: mode_rdy = (lfsr_q[7:0] < thresh_i);
        RDY_TOGGLE: mode_rdy = ~ready_q;
        RDY_BURST: begin
          // Zero-length phases collapse to a constant level; the counter
          // stays parked at ON/0 so a later non-zero length starts cleanly.
          if (on_len_i == '0 && off_len_i == '0) begin
            mode_rdy = 1'b1;
          end else if (on_len_i == '0) begin
            mode_rdy = 1'b0;
          end else if (off_len_i == '0) begin
            mode_rdy = 1'b1;
          end else begin
            mode_rdy   = phase_on_q;
            cnt_d      = cnt_inc[CNT_W-1:0];
            phase_on_d = phase_on_q;
            // >= so a length shrunk below the running count ends the phase
            if (cnt_inc >= {1'b0, (phase_on_q ? on_len_i : off_len_i)}) begin
              cnt_d      = '0;
              phase_on_d = ~phase_on_q;
            end
          end
        end
        RDY_LOW:  mode_rdy = 1'b0;
        default:  mode_rdy = 1'b1;
      endcase
      stall_d = ready_q ? 32'd0 : stall_q + 32'd1;
      ready_d = mode_rdy;
      if (MAX_STALL != 0 && stall_d == 32'(MAX_STALL)) ready_d = 1'b1;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q    <= 1'b0;
      lfsr_q     <= SEED;
      cnt_q      <= '0;
      phase_on_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      ready_q    <= ready_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      phase_on_q <= phase_on_d;
      stall_q    <= stall_d;
    end
  end

  assign ready_o = ready_q;

`ifdef READY_GEN_STATS_EN
  logic [31:0] stat_q;

  // Saturating count of enabled cycles spent with ready low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_q <= '0;
    end else if (en_i && !ready_q && stat_q != 32'hFFFF_FFFF) begin
      stat_q <= stat_q + 32'd1;
    end
  end

  assign stall_total_o = stat_q;
`else
  assign stall_total_o = '0;
`endif

endmodule

// File: rtl/ready_pattern_gen.sv
// Multi-channel backpressure generator for sink BFMs. One ready_chan_gen
// per channel; config buses are sliced per channel. Optional stats counters
// are enabled with READY_GEN_STATS_EN.
module ready_pattern_gen
  import ready_gen_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 8,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned MAX_STALL = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      en,
  input  logic [3*NUM_CH-1:0]    mode,
  input  logic [8*NUM_CH-1:0]    thresh,
  input  logic [CNT_W-1:0]       on_len,
  input  logic [CNT_W-1:0]       off_len,
  output logic [NUM_CH-1:0]      ready,
  output logic [32*NUM_CH-1:0]   stall_total
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ready_chan_gen #(
      .CNT_W     (CNT_W),
      .SEED      (chan_seed(SEED, c)),
      .MAX_STALL (MAX_STALL)
    ) u_chan (
      .clk_i         (clk),
      .rst_i         (rst),
      .en_i          (en[c]),
      .mode_i        (mode[3*c +: 3]),
      .thresh_i      (thresh[8*c +: 8]),
      .on_len_i      (on_len),
      .off_len_i     (off_len),
      .ready_o       (ready[c]),
      .stall_total_o (stall_total[32*c +: 32])
    );
  end

endmodule

// File: tb/tb_ready_pattern_gen.sv
// Self-checking bench: scoreboard queue of expected ready vectors per cycle.
module tb_ready_pattern_gen;

`ifdef READY_GEN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   en = '0;
  logic [11:0]  mode = 12'b011_011_011_011;
  logic [31:0]  thresh = '0;
  logic [7:0]   on_len = '0;
  logic [7:0]   off_len = '0;
  logic [3:0]   ready, ready_c;
  logic [127:0] st, st_c;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] s;
  } exp_t;
  exp_t sb[$];

  logic seq1[10000];

  always #5 clk = ~clk;

  ready_pattern_gen #(.NUM_CH(4), .CNT_W(8), .SEED(16'hACE1), .MAX_STALL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .thresh(thresh),
    .on_len(on_len), .off_len(off_len), .ready(ready), .stall_total(st));

  ready_pattern_gen #(.NUM_CH(4), .CNT_W(8), .SEED(16'hACE1), .MAX_STALL(4)) dut_cap (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .thresh(thresh),
    .on_len(on_len), .off_len(off_len), .ready(ready_c), .stall_total(st_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input int c, input logic [2:0] m);
    mode[3*c +: 3] = m;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = '0;
    mode = 12'b011_011_011_011;
    thresh = '0;
    on_len = '0;
    off_len = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b want 0000", ready);
    end
    checks++;
    if (ready_c !== 4'b0000) begin
      errors++; $display("FAIL reset_ready_cap: got %b want 0000", ready_c);
    end
    checks++;
    if (st !== '0) begin
      errors++; $display("FAIL reset_stats: got %h want 0", st);
    end
    rst = 1'b0;
    sb.push_back('{r: 4'b1111, s: 32'd0});
    tick();
    e = sb.pop_front();
    checks++;
    if (ready !== e.r) begin
      errors++; $display("FAIL post_reset_ready: got %b want %b", ready, e.r);
    end
  endtask

  task automatic test_toggle();
    exp_t e;
    logic prev = 1'b1;
    int   lows = 0;
    logic nr;
    do_reset();
    en = 4'b0001;
    set_mode(0, 3'd1);
    for (int i = 0; i < 8; i++) begin
      if (!prev) lows++;
      nr = ~prev;
      sb.push_back('{r: {3'b111, nr}, s: STATS ? 32'(lows) : 32'd0});
      prev = nr;
      tick();
      e = sb.pop_front();
      checks++;
      if (ready !== e.r) begin
        errors++; $display("FAIL toggle_ready cyc%0d: got %b want %b", i, ready, e.r);
      end
      checks++;
      if (st[31:0] !== e.s) begin
        errors++; $display("FAIL toggle_stats cyc%0d: got %0d want %0d", i, st[31:0], e.s);
      end
    end
  endtask

  task automatic test_burst();
    exp_t e;
    logic [4:0] pat = 5'b00111;  // bit k = k-th cycle of pattern 1,1,1,0,0
    do_reset();
    on_len = 8'd3;
    off_len = 8'd2;
    en = 4'b0010;
    set_mode(1, 3'd2);
    for (int i = 0; i < 15; i++) begin
      sb.push_back('{r: {2'b11, pat[i % 5], 1'b1}, s: 32'd0});
      tick();
      e = sb.pop_front();
      checks++;
      if (ready !== e.r) begin
        errors++; $display("FAIL burst_3_2 cyc%0d: got %b want %b", i, ready, e.r);
      end
    end
    on_len = 8'd0;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{r: 4'b1101, s: 32'd0});
      tick();
      e = sb.pop_front();
      checks++;
      if (ready !== e.r) begin
        errors++; $display("FAIL burst_on0 cyc%0d: got %b want %b", i, ready, e.r);
      end
    end
    off_len = 8'd0;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{r: 4'b1111, s: 32'd0});
      tick();
      e = sb.pop_front();
      checks++;
      if (ready !== e.r) begin
        errors++; $display("FAIL burst_00 cyc%0d: got %b want %b", i, ready, e.r);
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic [15:0] lfsr;
    logic        b;
    int          highs = 0;
    do_reset();
    lfsr = 16'h9FD2;  // 16'hACE1 ^ (16'h1111*3) for channel 2
    thresh[23:16] = 8'd128;
    en = 4'b0100;
    set_mode(2, 3'd0);
    for (int i = 0; i < 10000; i++) begin
      b = (lfsr[7:0] < 8'd128);
      lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      sb.push_back('{r: {1'b1, b, 2'b11}, s: 32'd0});
      tick();
      e = sb.pop_front();
      seq1[i] = ready[2];
      if (ready[2]) highs++;
      checks++;
      if (ready !== e.r) begin
        errors++; $display("FAIL random_seq cyc%0d: got %b want %b", i, ready, e.r);
      end
    end
    checks++;
    if (highs < 4500 || highs > 5500) begin
      errors++; $display("FAIL random_fraction: got %0d highs want 4500..5500", highs);
    end
    // Same seed after reset must replay the identical sequence.
    do_reset();
    thresh[23:16] = 8'd128;
    en = 4'b0100;
    set_mode(2, 3'd0);
    for (int i = 0; i < 2000; i++) begin
      tick();
      checks++;
      if (ready[2] !== seq1[i]) begin
        errors++; $display("FAIL random_replay cyc%0d: got %b want %b", i, ready[2], seq1[i]);
      end
    end
    thresh[23:16] = 8'd0;
    tick();
    for (int i = 0; i < 50; i++) begin
      sb.push_back('{r: 4'b1011, s: 32'd0});
      tick();
      e = sb.pop_front();
      checks++;
      if (ready !== e.r) begin
        errors++; $display("FAIL random_thresh0 cyc%0d: got %b want %b", i, ready, e.r);
      end
    end
  endtask

  task automatic test_stall_cap();
    exp_t e;
    logic [4:0] pat = 5'b10000;  // 0,0,0,0,1
    int   lows = 0;
    do_reset();
    en = 4'b1000;
    set_mode(3, 3'd4);
    for (int i = 0; i < 15; i++) begin
      if (i > 0) lows++;
      sb.push_back('{r: {pat[i % 5], 3'b111}, s: STATS ? 32'(lows) : 32'd0});
      tick();
      e = sb.pop_front();
      checks++;
      if (ready_c !== e.r) begin
        errors++; $display("FAIL stall_cap4 cyc%0d: got %b want %b", i, ready_c, e.r);
      end
      checks++;
      if (ready !== 4'b0111) begin
        errors++; $display("FAIL stall_cap0 cyc%0d: got %b want 0111", i, ready);
      end
      checks++;
      if (st[127:96] !== e.s) begin
        errors++; $display("FAIL stall_stats cyc%0d: got %0d want %0d", i, st[127:96], e.s);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [4:0] pat = 5'b00111;
    do_reset();
    on_len = 8'd3;
    off_len = 8'd2;
    en = 4'b0010;
    set_mode(1, 3'd2);
    tick();
    tick();
    checks++;
    if (ready !== 4'b1111) begin
      errors++; $display("FAIL async_pre: got %b want 1111", ready);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (ready !== 4'b0000 || ready_c !== 4'b0000) begin
      errors++; $display("FAIL async_reset: got %b/%b want 0000", ready, ready_c);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{r: {2'b11, pat[i % 5], 1'b1}, s: 32'd0});
      tick();
      e = sb.pop_front();
      checks++;
      if (ready !== e.r) begin
        errors++; $display("FAIL async_restart cyc%0d: got %b want %b", i, ready, e.r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_burst();
    test_random();
    test_stall_cap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ready_pattern_gen.md
Name: ready_pattern_gen

Overview:
- Multi-channel, parametrised backpressure generator for BFM sinks.
- Drives one ready per channel using a per-channel mode: LFSR random with programmable probability, toggle, burst on/off, constant high, or constant low.
- Optional stall-liveness cap prevents infinite backpressure.
- Instantiated in testbenches beside AXI-S/Avalon sink BFMs; deterministic and seedable, so failures reproduce.

Parameters:
- NUM_CH, 4, number of independent ready channels (1..32).
- CNT_W, 8, width of burst on/off length inputs and internal phase counter.
- SEED, 16'hACE1, base LFSR seed. Channel c uses SEED ^ (16'h1111*(c+1)); a zero result is replaced by 16'h0001.
- MAX_STALL, 0, consecutive-low cap. 0 disables the cap; otherwise ready is forced high after MAX_STALL consecutive low cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  NUM_CH  per-channel enable. Low means the channel's ready is held high.
- mode  in  3*NUM_CH  per-channel mode; channel c uses bits [3c+2:3c].
- thresh  in  8*NUM_CH  per-channel random threshold (RANDOM mode).
- on_len  in  CNT_W  shared burst high length, in cycles.
- off_len  in  CNT_W  shared burst low length, in cycles.
- ready  out  NUM_CH  generated ready.
- stall_total  out  32*NUM_CH  per-channel count of enabled ready-low cycles (see Optional Feature).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - ready = 0 on all channels.
  - LFSRs = per-channel seed.
  - Phase counters = 0; burst phase = ON.
  - Stall counters = 0; stall_total = 0.
- Registered output: every decision is registered, so ready changes exactly 1 cycle after the inputs that caused it.
- LFSR: 16-bit Galois, taps 16'hB400, shifts right. Advances every cycle that en[c]=1, regardless of mode. Holds while en[c]=0.
- en[c]=0: next ready[c]=1. Phase counter and stall counter clear; burst phase returns to ON.
- Modes when en[c]=1 (next-cycle ready):
  - 0 RANDOM: 1 when lfsr[7:0] < thresh[c], else 0. thresh=0 gives always low; thresh=255 gives 255/256 high.
  - 1 TOGGLE: ~ready[c].
  - 2 BURST: ON phase drives 1 for on_len cycles, then OFF phase drives 0 for off_len cycles, repeating. A length of 0 skips that phase. If both lengths are 0, output is 1.
  - 3 HIGH: 1.
  - 4 LOW: 0.
  - 5-7: treated as HIGH.
- Mode change on a channel: burst counter clears and phase restarts at ON on the cycle after the change. A change of on_len/off_len mid-phase takes effect at the next phase boundary comparison (counter compared against the live value).
- Stall cap (MAX_STALL>0): the stall counter increments each enabled cycle ready[c]=0 and clears when ready[c]=1. When the counter equals MAX_STALL, next ready[c]=1, overriding the mode. The burst phase counter still advances.
- Simultaneous en fall and mode change: the en rule wins.
- Asynchronous reset mid-burst: all state returns to reset values immediately.

Optional Feature:
- Macro READY_GEN_STATS_EN.
- Defined: stall_total[c] increments each cycle where en[c]=1 and ready[c]=0, and saturates at 32'hFFFFFFFF.
- Undefined: no counters are synthesised and stall_total is tied to 0. The port list is identical in both cases.

Decomposition:
- Package ready_gen_pkg holds:
  - enum rdy_mode_e (RDY_RANDOM=0, RDY_TOGGLE, RDY_BURST, RDY_HIGH, RDY_LOW);
  - LFSR_TAPS = 16'hB400;
  - function chan_seed(SEED, c).
- Sub-module ready_chan_gen: one channel (LFSR, phase counter, stall counter, stats). The top generates NUM_CH instances and slices the packed config buses.

Test Plan:
- Reset, then en=0 → ready=0 during rst. Beginning 1 cycle after rst falls, ready=1 on all channels.
- Ch0 TOGGLE, en=1 → ready alternates 1,0,1,0 starting from the value held at en rise. stall_total[0] increments on every low cycle (with STATS_EN).
- Ch1 BURST, on_len=3, off_len=2 → repeating pattern 1,1,1,0,0. Switching to on_len=0 gives constant 0. Switching to on_len=0, off_len=0 gives constant 1.
- Ch2 RANDOM, thresh=128, 10000 cycles → high fraction 0.45-0.55. A rerun with the same SEED gives a bit-identical sequence. thresh=0 → always 0.
- MAX_STALL=4, ch3 LOW → pattern 0,0,0,0,1 repeating. With MAX_STALL=0 → constant 0.
- Assert rst mid-burst on ch1 → ready=0 immediately (asynchronous). After release, the burst restarts in the ON phase.
